// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add: iterative unsigned shift-add multiplier.
// One multiplier bit per clock, start/busy/done handshake.
module seq_mult_shift_add #(
  parameter int XW = 3,
  parameter int YW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  output logic            busy,
  output logic            done,
  output logic [XW+YW-1:0] p
);

  localparam int PW = XW + YW;
  localparam int CW = $clog2(YW + 1);
  localparam logic [CW-1:0] LAST = CW'(YW - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] xr_q, xr_d;
  logic [YW-1:0] yr_q, yr_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] acc_sum;

  // Partial-product add for the current multiplier bit
  always_comb begin
    acc_sum = acc_q + (yr_q[0] ? xr_q : '0);
  end

  // Next-state and datapath control; done is a one-cycle pulse
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          xr_d    = {{YW{1'b0}}, x};
          yr_d    = y;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        xr_d  = xr_q << 1;
        yr_d  = yr_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          p_d     = acc_sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// tb_seq_mult_shift_add: three configurations against a
// latency/product model, plus directed literal checks.
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Instance A: XW=3 YW=2
  logic rstA = 1'b0, startA = 1'b0;
  logic [2:0] xA = '0;
  logic [1:0] yA = '0;
  logic busyA, doneA;
  logic [4:0] pA;
  // Instance B: XW=8 YW=8
  logic rstB = 1'b0, startB = 1'b0;
  logic [7:0] xB = '0;
  logic [7:0] yB = '0;
  logic busyB, doneB;
  logic [15:0] pB;
  // Instance C: XW=4 YW=4
  logic rstC = 1'b0, startC = 1'b0;
  logic [3:0] xC = '0;
  logic [3:0] yC = '0;
  logic busyC, doneC;
  logic [7:0] pC;

  seq_mult_shift_add #(.XW(3), .YW(2)) u_a (
    .clk(clk), .rst(rstA), .start(startA), .x(xA), .y(yA),
    .busy(busyA), .done(doneA), .p(pA));
  seq_mult_shift_add #(.XW(8), .YW(8)) u_b (
    .clk(clk), .rst(rstB), .start(startB), .x(xB), .y(yB),
    .busy(busyB), .done(doneB), .p(pB));
  seq_mult_shift_add #(.XW(4), .YW(4)) u_c (
    .clk(clk), .rst(rstC), .start(startC), .x(xC), .y(yC),
    .busy(busyC), .done(doneC), .p(pC));

  // Model: an accepted start yields x*y and a done pulse YW
  // cycles later; everything else is held.
  typedef struct {
    int          rem;
    bit          busy;
    bit          done;
    int unsigned p;
    int unsigned pend;
  } mdl_t;

  mdl_t mA = '{default: 0};
  mdl_t mB = '{default: 0};
  mdl_t mC = '{default: 0};

  function automatic mdl_t step(mdl_t m, logic s,
                                int unsigned a, int unsigned b, int yw);
    mdl_t n = m;
    n.done = 1'b0;
    if (m.rem > 0) begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.done = 1'b1;
        n.busy = 1'b0;
        n.p    = m.pend;
      end
    end else if (s === 1'b1) begin
      n.pend = a * b;
      n.rem  = yw;
      n.busy = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rstA)
    if (rstA) mA <= '{default: 0};
    else mA <= step(mA, startA, 32'(xA), 32'(yA), 2);
  always @(posedge clk or posedge rstB)
    if (rstB) mB <= '{default: 0};
    else mB <= step(mB, startB, 32'(xB), 32'(yB), 8);
  always @(posedge clk or posedge rstC)
    if (rstC) mC <= '{default: 0};
    else mC <= step(mC, startC, 32'(xC), 32'(yC), 4);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Compare every instance against the model each cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("A_busy", 32'(busyA), 32'(mA.busy));
      chk("A_done", 32'(doneA), 32'(mA.done));
      chk("A_p",    32'(pA),    mA.p);
      chk("B_busy", 32'(busyB), 32'(mB.busy));
      chk("B_done", 32'(doneB), 32'(mB.done));
      chk("B_p",    32'(pB),    mB.p);
      chk("C_busy", 32'(busyC), 32'(mC.busy));
      chk("C_done", 32'(doneC), 32'(mC.done));
      chk("C_p",    32'(pC),    mC.p);
    end
  end

  task automatic wait_done(input int k, output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((k == 0 && doneA) || (k == 1 && doneB) ||
          (k == 2 && doneC)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  bit got;
  int t0;
  int last;
  int cnt;

  initial begin
    #1;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_p", 32'(pB), 0);
    chk("rst_busy", 32'(busyB), 0);
    chk("rst_done", 32'(doneA), 0);
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    @(negedge clk);

    // 7*3 at defaults
    startA = 1'b1; xA = 3'd7; yA = 2'd3;
    @(negedge clk); startA = 1'b0;
    chk("a73_busy1", 32'(busyA), 1);
    chk("a73_done1", 32'(doneA), 0);
    @(negedge clk);
    chk("a73_busy2", 32'(busyA), 1);
    chk("a73_done2", 32'(doneA), 0);
    @(negedge clk);
    chk("a73_done3", 32'(doneA), 1);
    chk("a73_busy3", 32'(busyA), 0);
    chk("a73_p", 32'(pA), 21);
    @(negedge clk);
    chk("a73_done4", 32'(doneA), 0);
    chk("a73_hold", 32'(pA), 21);
    chk("a73_model", mA.p, 21);

    // Exhaustive back-to-back, start in each done cycle
    last = 0;
    for (int i = 0; i < 32; i++) begin
      startA = 1'b1;
      xA = 3'(i >> 2);
      yA = 2'(i);
      @(negedge clk); startA = 1'b0;
      wait_done(0, got);
      chk("exh_done", 32'(got), 1);
      chk("exh_p", 32'(pA), 32'((i >> 2) * (i & 3)));
      if (i > 0) chk("exh_gap", 32'(cyc - last), 3);
      last = cyc;
    end
    @(negedge clk);

    // 255*255
    startB = 1'b1; xB = 8'd255; yB = 8'd255;
    @(negedge clk); startB = 1'b0; t0 = cyc;
    wait_done(1, got);
    chk("b_max_lat", 32'(cyc - t0), 8);
    chk("b_max_p", 32'(pB), 32'h0000_FE01);
    chk("b_max_model", mB.p, 65025);

    // 0*200
    @(negedge clk);
    startB = 1'b1; xB = 8'd0; yB = 8'd200;
    @(negedge clk); startB = 1'b0; t0 = cyc;
    wait_done(1, got);
    chk("b_zero_lat", 32'(cyc - t0), 8);
    chk("b_zero_p", 32'(pB), 0);

    // start while busy is ignored
    @(negedge clk);
    startB = 1'b1; xB = 8'd10; yB = 8'd12;
    @(negedge clk); startB = 1'b0; t0 = cyc;
    @(negedge clk);
    startB = 1'b1; xB = 8'd99; yB = 8'd99;
    @(negedge clk); startB = 1'b0;
    wait_done(1, got);
    chk("b_busy_lat", 32'(cyc - t0), 8);
    chk("b_busy_p", 32'(pB), 120);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (busyB || doneB) cnt++;
    end
    chk("b_busy_noop", 32'(cnt), 0);

    // Asynchronous reset mid-operation
    startB = 1'b1; xB = 8'd13; yB = 8'd11;
    @(negedge clk); startB = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstB = 1'b1;
    #1;
    chk("b_rst_busy", 32'(busyB), 0);
    chk("b_rst_done", 32'(doneB), 0);
    chk("b_rst_p", 32'(pB), 0);
    @(negedge clk); rstB = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (doneB || busyB) cnt++;
    end
    chk("b_rst_nodone", 32'(cnt), 0);
    startB = 1'b1; xB = 8'd3; yB = 8'd5;
    @(negedge clk); startB = 1'b0; t0 = cyc;
    wait_done(1, got);
    chk("b_post_lat", 32'(cyc - t0), 8);
    chk("b_post_p", 32'(pB), 15);

    // Operand hold: inputs churn during RUN
    startC = 1'b1; xC = 4'd9; yC = 4'd6;
    @(negedge clk); startC = 1'b0; t0 = cyc;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      xC = 4'($urandom);
      yC = 4'($urandom);
      @(negedge clk);
      if (doneC) begin
        got = 1'b1;
        break;
      end
    end
    chk("c_hold_done", 32'(got), 1);
    chk("c_hold_lat", 32'(cyc - t0), 4);
    chk("c_hold_p", 32'(pC), 54);

    // Random traffic on all three against the model
    fork
      repeat (400) begin
        @(negedge clk);
        startA = 1'($urandom_range(0, 1));
        xA = 3'($urandom);
        yA = 2'($urandom);
      end
      repeat (400) begin
        @(negedge clk);
        startB = 1'($urandom_range(0, 3) == 0);
        xB = 8'($urandom);
        yB = 8'($urandom);
      end
      repeat (400) begin
        @(negedge clk);
        startC = 1'($urandom_range(0, 2) == 0);
        xC = 4'($urandom);
        yC = 4'($urandom);
      end
    join
    @(negedge clk);
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
